i2cmb_wb_sequencer: RTL and testbench

I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

---
 rtl/i2cmb_wb_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// Byte-level I2C transaction sequencer driving an I2C multi-bus controller over Wishbone.
// One request runs: [enable] -> set bus -> START -> address -> data byte -> STOP -> response.
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_rw_i,
    input  logic [3:0]               req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic [7:0]               req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [1:0]               rsp_status_o,
    output logic [7:0]               rsp_rdata_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [7:0] CSR_EN    = 8'hC0;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_START = 8'h04;
    localparam logic [7:0] CMD_STOP  = 8'h05;
    localparam logic [7:0] CMD_SETB  = 8'h06;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_NAK = 2'd1;
    localparam logic [1:0] ST_AL  = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_EN, S_BUS_DPR, S_BUS_CMD, S_START, S_ADR_DPR, S_ADR_CMD,
        S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_STOP, S_WAIT, S_RESP
    } state_t;

    state_t          state, ret_state;
    logic            busy, en_done, in_stop, rw_q;
    logic [3:0]      bus_q;
    logic [6:0]      addr_q;
    logic [7:0]      wdata_q, rdata_q;
    logic [1:0]      status_q;
    logic [CW-1:0]   tmo_cnt;

    // Access descriptor for the current step: what to put on the bus and where to go after ack.
    logic                     acc_we;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [7:0]               acc_dat;
    state_t                   acc_next, acc_ret;

    always_comb begin
        acc_we   = 1'b1;
        acc_adr  = A_CMDR;
        acc_dat  = 8'h00;
        acc_next = S_WAIT;
        acc_ret  = S_RESP;
        case (state)
            S_EN:      begin acc_adr = A_CSR; acc_dat = CSR_EN; acc_next = S_BUS_DPR; end
            S_BUS_DPR: begin acc_adr = A_DPR; acc_dat = {4'h0, bus_q}; acc_next = S_BUS_CMD; end
            S_BUS_CMD: begin acc_dat = CMD_SETB;  acc_ret = S_START; end
            S_START:   begin acc_dat = CMD_START; acc_ret = S_ADR_DPR; end
            S_ADR_DPR: begin acc_adr = A_DPR; acc_dat = {addr_q, rw_q}; acc_next = S_ADR_CMD; end
            S_ADR_CMD: begin acc_dat = CMD_WRITE; acc_ret = rw_q ? S_RD_CMD : S_WR_DPR; end
            S_WR_DPR:  begin acc_adr = A_DPR; acc_dat = wdata_q; acc_next = S_WR_CMD; end
            S_WR_CMD:  begin acc_dat = CMD_WRITE; acc_ret = S_STOP; end
            S_RD_CMD:  begin acc_dat = CMD_READ;  acc_ret = S_RD_DPR; end
            S_RD_DPR:  begin acc_we = 1'b0; acc_adr = A_DPR; acc_next = S_STOP; end
            S_STOP:    begin acc_dat = CMD_STOP;  acc_ret = S_RESP; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            ret_state    <= S_IDLE;
            busy         <= 1'b0;
            en_done      <= 1'b0;
            in_stop      <= 1'b0;
            rw_q         <= 1'b0;
            bus_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            status_q     <= ST_OK;
            tmo_cnt      <= '0;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= '0;
            rsp_rdata_o  <= '0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (req_valid_i && req_ready_o) begin
                        rw_q     <= req_rw_i;
                        bus_q    <= req_bus_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        rdata_q  <= '0;
                        status_q <= ST_OK;
                        in_stop  <= 1'b0;
                        if ({28'd0, req_bus_i} >= 32'(NUM_I2C_BUSSES)) begin
                            // Bad bus index: answer straight from IDLE, no bus traffic.
                            rsp_valid_o  <= 1'b1;
                            rsp_status_o <= ST_ERR;
                            rsp_rdata_o  <= '0;
                        end else begin
                            req_ready_o <= 1'b0;
                            state       <= en_done ? S_BUS_DPR : S_EN;
                        end
                    end
                end

                S_WAIT: begin
                    if (!busy) begin
                        if (irq_i) begin
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            we_o  <= 1'b0;
                            adr_o <= A_CMDR;
                            busy  <= 1'b1;
                        end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            status_q <= ST_ERR;
                            state    <= S_RESP;
                        end else begin
                            tmo_cnt <= tmo_cnt + CW'(1);
                        end
                    end else if (ack_i) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                        if (dat_i[5]) begin
                            status_q <= ST_AL;
                            state    <= S_RESP;
                        end else if (dat_i[4]) begin
                            status_q <= ST_ERR;
                            state    <= S_RESP;
                        end else if (dat_i[6]) begin
                            // NAK during STOP cannot retry STOP; keep any earlier status.
                            if (!in_stop) begin
                                status_q <= ST_NAK;
                                state    <= S_STOP;
                            end else begin
                                if (status_q == ST_OK) status_q <= ST_NAK;
                                state <= S_RESP;
                            end
                        end else if (dat_i[7]) begin
                            state <= ret_state;
                        end else begin
                            status_q <= ST_ERR;
                            state    <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    rsp_valid_o  <= 1'b1;
                    rsp_status_o <= status_q;
                    rsp_rdata_o  <= (status_q == ST_OK && rw_q) ? rdata_q : 8'h00;
                    req_ready_o  <= 1'b1;
                    state        <= S_IDLE;
                end

                default: begin
                    tmo_cnt <= '0;
                    if (!busy) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= acc_we;
                        adr_o <= acc_adr;
                        dat_o <= WB_DATA_WIDTH'(acc_dat);
                        busy  <= 1'b1;
                    end else if (ack_i) begin
                        // Dropping cyc here and re-raising next state leaves one idle cycle.
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        busy      <= 1'b0;
                        state     <= acc_next;
                        ret_state <= acc_ret;
                        if (state == S_EN)     en_done <= 1'b1;
                        if (state == S_RD_DPR) rdata_q <= 8'(dat_i);
                        if (state == S_STOP)   in_stop <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Scoreboard bench: expected Wishbone accesses and responses are queued by the stimulus,
// a slave model checks each access as it is acked and a monitor checks each response.
module tb_i2cmb_wb_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [3:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [7:0] rsp_rdata;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack = 1'b0;
    logic       irq = 1'b0;

    i2cmb_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .NUM_I2C_BUSSES(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_rdata_o(rsp_rdata),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack), .irq_i(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [1:0] adr; logic [7:0] dat; } wb_t;
    typedef struct packed { logic [1:0] status; logic [7:0] rdata; } rsp_t;

    wb_t        wb_exp[$];
    rsp_t       rsp_exp[$];
    logic [7:0] cmdr_q[$];
    logic [7:0] rd_byte = 8'h00;
    logic       auto_irq = 1'b1;
    logic       stall = 1'b0;
    int         irq_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic pw(input logic [1:0] a, input logic [7:0] d);
        wb_exp.push_back('{we: 1'b1, adr: a, dat: d});
    endtask

    task automatic pr(input logic [1:0] a);
        wb_exp.push_back('{we: 1'b0, adr: a, dat: 8'h00});
    endtask

    // Wishbone slave: acks every strobe on the following negedge and checks it against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0; irq = 1'b0; irq_cnt = 0; dat_i = '0;
            end else begin
                ack = 1'b0;
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) irq = 1'b1;
                end
                if (cyc && stb && !(stall && we && adr == 2'd2 && dat_o == 8'h01)) begin
                    wb_t e;
                    ack = 1'b1;
                    checks++;
                    if (wb_exp.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected: got we=%0b adr=%0d dat=%02h, none expected", we, adr, dat_o);
                    end else begin
                        e = wb_exp.pop_front();
                        if (we !== e.we || adr !== e.adr || (e.we && dat_o !== e.dat)) begin
                            errors++;
                            $display("FAIL wb_access: got we=%0b adr=%0d dat=%02h want we=%0b adr=%0d dat=%02h",
                                     we, adr, dat_o, e.we, e.adr, e.dat);
                        end
                    end
                    if (!we && adr == 2'd2) begin
                        if (cmdr_q.size() > 0) dat_i = cmdr_q.pop_front();
                        else dat_i = 8'h80;
                        irq = 1'b0;
                    end else if (!we && adr == 2'd1) begin
                        dat_i = rd_byte;
                    end else if (we && adr == 2'd2 && auto_irq) begin
                        irq_cnt = 3;
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_t e;
                checks++;
                if (rsp_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got status=%0d rdata=%02h, none expected", rsp_status, rsp_rdata);
                end else begin
                    e = rsp_exp.pop_front();
                    if (rsp_status !== e.status || rsp_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rsp: got status=%0d rdata=%02h want status=%0d rdata=%02h",
                                 rsp_status, rsp_rdata, e.status, e.rdata);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic rw, input logic [3:0] bus, input logic [6:0] a, input logic [7:0] wd);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_rw = rw; req_bus = bus; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((wb_exp.size() != 0 || rsp_exp.size() != 0) && n < 1000) begin @(negedge clk); n++; end
        chk(name, 32'(wb_exp.size() + rsp_exp.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic exp_front(input logic [7:0] dpr_addr);
        pw(2'd1, 8'h00); pw(2'd2, 8'h06); pr(2'd2); pw(2'd2, 8'h04); pr(2'd2);
        pw(2'd1, dpr_addr); pw(2'd2, 8'h01); pr(2'd2);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_cyc_stb_we", {29'd0, cyc, stb, we}, 32'd0);
        chk("rst_adr_dat", {22'd0, adr, dat_o}, 32'd0);
        chk("rst_rsp", {21'd0, rsp_valid, rsp_status, rsp_rdata}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0xA5 to 0x22: first request includes the CSR enable write
        pw(2'd0, 8'hC0); exp_front(8'h44);
        pw(2'd1, 8'hA5); pw(2'd2, 8'h01); pr(2'd2); pw(2'd2, 8'h05); pr(2'd2);
        rsp_exp.push_back('{status: 2'd0, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h22, 8'hA5);
        chk("busy_ready_low", 32'(req_ready), 32'd0);
        wait_done("write_ok_done");

        // Read 0x22 returning 0x5A, no CSR write
        rd_byte = 8'h5A;
        exp_front(8'h45);
        pw(2'd2, 8'h03); pr(2'd2); pr(2'd1); pw(2'd2, 8'h05); pr(2'd2);
        rsp_exp.push_back('{status: 2'd0, rdata: 8'h5A});
        do_req(1'b1, 4'd0, 7'h22, 8'h00);
        wait_done("read_ok_done");

        // Read with address NAK: STOP issued, rdata forced to 0
        cmdr_q = '{8'h80, 8'h80, 8'h40, 8'h80};
        exp_front(8'h45); pw(2'd2, 8'h05); pr(2'd2);
        rsp_exp.push_back('{status: 2'd1, rdata: 8'h00});
        do_req(1'b1, 4'd0, 7'h22, 8'h00);
        wait_done("read_nak_done");

        // Write with address NAK: no data byte
        cmdr_q = '{8'h80, 8'h80, 8'h40, 8'h80};
        exp_front(8'hA0); pw(2'd2, 8'h05); pr(2'd2);
        rsp_exp.push_back('{status: 2'd1, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h50, 8'h11);
        wait_done("write_nak_done");

        // Arbitration lost after START: no STOP
        cmdr_q = '{8'h80, 8'h20};
        pw(2'd1, 8'h00); pw(2'd2, 8'h06); pr(2'd2); pw(2'd2, 8'h04); pr(2'd2);
        rsp_exp.push_back('{status: 2'd2, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h22, 8'h33);
        wait_done("al_done");

        // All bits set: AL wins
        cmdr_q = '{8'h80, 8'h80, 8'hF0};
        exp_front(8'h44);
        rsp_exp.push_back('{status: 2'd2, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h22, 8'h33);
        wait_done("prio_al_done");

        // ERR + NAK: ERR wins, no STOP
        cmdr_q = '{8'h80, 8'h80, 8'h50};
        exp_front(8'h44);
        rsp_exp.push_back('{status: 2'd3, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h22, 8'h33);
        wait_done("prio_err_done");

        // Bus index out of range: status 3, no Wishbone traffic
        rsp_exp.push_back('{status: 2'd3, rdata: 8'h00});
        do_req(1'b0, 4'd1, 7'h22, 8'h33);
        wait_done("bad_bus_done");

        // irq never arrives: timeout status 3
        auto_irq = 1'b0;
        pw(2'd1, 8'h00); pw(2'd2, 8'h06);
        rsp_exp.push_back('{status: 2'd3, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h22, 8'h33);
        wait_done("timeout_done");
        auto_irq = 1'b1;

        // Reset while the address command is on the bus
        stall = 1'b1;
        pw(2'd1, 8'h00); pw(2'd2, 8'h06); pr(2'd2); pw(2'd2, 8'h04); pr(2'd2); pw(2'd1, 8'h44);
        do_req(1'b0, 4'd0, 7'h22, 8'h77);
        n = 0;
        while (!(cyc && stb && we && adr == 2'd2 && dat_o == 8'h01) && n < 500) begin @(negedge clk); n++; end
        chk("adr_cmd_reached", 32'(cyc && stb && we && adr == 2'd2 && dat_o == 8'h01), 32'd1);
        chk("pre_reset_queue", 32'(wb_exp.size()), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);

        // Next request must re-enable the controller
        pw(2'd0, 8'hC0); exp_front(8'h44);
        pw(2'd1, 8'h3C); pw(2'd2, 8'h01); pr(2'd2); pw(2'd2, 8'h05); pr(2'd2);
        rsp_exp.push_back('{status: 2'd0, rdata: 8'h00});
        do_req(1'b0, 4'd0, 7'h22, 8'h3C);
        wait_done("post_reset_done");

        chk("cmdr_q_drained", 32'(cmdr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
